// File: rtl/apple2_dsk_uart_tx_if.sv
// BRAM read port between the disk-image transmitter (master) and the image memory (slave).
interface apple2_dsk_uart_tx_if #(
  parameter int ADDR_W = 18
) ();
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_en, output mem_addr, input mem_data);
  modport slave  (input mem_en, input mem_addr, output mem_data);
endinterface

// File: rtl/apple2_dsk_uart_tx.sv
// Streams a disk image out of BRAM as back-to-back 8N1 frames on txd.
// Define DSK_TX_CHECKSUM_EN to append an 8-bit modular checksum frame after the image.
module apple2_dsk_uart_tx #(
  parameter int CLK_HZ = 125000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 18
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  apple2_dsk_uart_tx_if.master mem,
  output logic                txd,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   bytes_sent
);
  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int CNT_W   = $clog2(DIVISOR + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, START, DATA, STOP,
`ifdef DSK_TX_CHECKSUM_EN
    CKSUM,
`endif
    FINISH
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [ADDR_W-1:0] nxt_off;
  logic              pref;
  logic              abort_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [7:0]        shift;
  logic              bit_end;
  logic              cap;
  logic              stop_end;
`ifdef DSK_TX_CHECKSUM_EN
  logic              cksum_frm;
  logic [7:0]        sum;
  logic              ld_ck;
`endif

  always_comb begin
    bit_end  = (cnt == CNT_W'(DIVISOR - 1));
    stop_end = (state == STOP) && bit_end;
    // Read data lands one cycle after mem_en: in LATCH, or the second STOP cycle of a prefetch.
    cap      = (state == LATCH) || ((state == STOP) && (cnt == CNT_W'(1)) && pref);
`ifdef DSK_TX_CHECKSUM_EN
    ld_ck    = stop_end && !pref && !abort_q && !abort && !cksum_frm;
`endif
  end

  // Datapath registers carry no reset; every use is preceded by a load.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q <= base_addr;
      len_q  <= length;
      shift  <= '0;
    end else if (cap) begin
      shift <= mem.mem_data;
`ifdef DSK_TX_CHECKSUM_EN
    end else if (ld_ck) begin
      shift <= sum;
`endif
    end else if (state == DATA && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end
`ifdef DSK_TX_CHECKSUM_EN
    if (state == IDLE && start) sum <= '0;
    else if (cap)               sum <= sum + mem.mem_data;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      txd          <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.mem_en   <= 1'b0;
      mem.mem_addr <= '0;
      bytes_sent   <= '0;
      cnt          <= '0;
      bit_idx      <= '0;
      nxt_off      <= '0;
      pref         <= 1'b0;
      abort_q      <= 1'b0;
`ifdef DSK_TX_CHECKSUM_EN
      cksum_frm    <= 1'b0;
`endif
    end else begin
      mem.mem_en <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            bytes_sent <= '0;
            abort_q    <= 1'b0;
            cnt        <= '0;
            pref       <= 1'b0;
`ifdef DSK_TX_CHECKSUM_EN
            cksum_frm  <= 1'b0;
`endif
            if (length == '0) begin
`ifdef DSK_TX_CHECKSUM_EN
              state     <= CKSUM;
              txd       <= 1'b0;
              cksum_frm <= 1'b1;
`else
              state     <= FINISH;
              done      <= 1'b1;
`endif
            end else begin
              state        <= FETCH;
              mem.mem_en   <= 1'b1;
              mem.mem_addr <= base_addr;
              nxt_off      <= ADDR_W'(1);
            end
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          state <= START;
          txd   <= 1'b0;
          cnt   <= '0;
        end
`ifdef DSK_TX_CHECKSUM_EN
        START, CKSUM: begin
`else
        START: begin
`endif
          if (bit_end) begin
            state   <= DATA;
            txd     <= shift[0];
            bit_idx <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
              // Prefetch so the next start bit follows this stop bit with no gap.
              if (nxt_off != len_q && !abort_q && !abort
`ifdef DSK_TX_CHECKSUM_EN
                  && !cksum_frm
`endif
                 ) begin
                mem.mem_en   <= 1'b1;
                mem.mem_addr <= base_q + nxt_off;
                nxt_off      <= nxt_off + ADDR_W'(1);
                pref         <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
`ifdef DSK_TX_CHECKSUM_EN
            if (!cksum_frm) bytes_sent <= bytes_sent + ADDR_W'(1);
`else
            bytes_sent <= bytes_sent + ADDR_W'(1);
`endif
            if (pref) begin
              state <= START;
              txd   <= 1'b0;
              pref  <= 1'b0;
            end else if (abort_q || abort) begin
              state   <= IDLE;
              busy    <= 1'b0;
              abort_q <= 1'b0;
`ifdef DSK_TX_CHECKSUM_EN
            end else if (ld_ck) begin
              state     <= CKSUM;
              txd       <= 1'b0;
              cksum_frm <= 1'b1;
`endif
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FINISH: begin
          state   <= IDLE;
          busy    <= 1'b0;
          abort_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple2_dsk_uart_tx.sv
// Directed bench for apple2_dsk_uart_tx at DIVISOR=16 (CLK_HZ=16, BAUD=1).
module tb_apple2_dsk_uart_tx;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              txd, busy, done;
  logic [ADDR_W-1:0] bytes_sent;
  logic [7:0]        bram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  apple2_dsk_uart_tx_if #(.ADDR_W(ADDR_W)) mem_if ();

  apple2_dsk_uart_tx #(.CLK_HZ(16), .BAUD(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .mem(mem_if.master),
    .txd(txd), .busy(busy), .done(done), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_if.mem_en) mem_if.mem_data <= bram[mem_if.mem_addr];
  end

  always_ff @(posedge clk) begin
    if (mem_if.mem_en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= mem_if.mem_addr;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Entered on the first start-bit cycle; leaves on the cycle after the stop bit.
  task automatic recv(output logic [7:0] b, output logic ok, input int abort_at);
    int j;
    ok = 1'b1;
    b  = 8'h00;
    for (int k = 0; k < 160; k++) begin
      if (k % 16 == 8) begin
        j = k / 16;
        if (j == 0)      ok = ok & (txd === 1'b0);
        else if (j == 9) ok = ok & (txd === 1'b1);
        else             b[j-1] = txd;
      end
      abort = (k == abort_at);
      tick();
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    logic       bad;
    int         e0, d0;

    bram[18'h00100] = 8'h55; bram[18'h00101] = 8'hA3; bram[18'h00102] = 8'h00;
    bram[18'h3FFFF] = 8'h12; bram[18'h00000] = 8'h34;
    bram[18'h00200] = 8'h11; bram[18'h00201] = 8'h22; bram[18'h00202] = 8'h33;
    bram[18'h00203] = 8'h44; bram[18'h00204] = 8'h55;

    // Reset state and quiet idle
    tick(); tick();
    check("rst_state", {txd, busy, done, mem_if.mem_en}, 4'b1000);
    check("rst_addr_cnt", {mem_if.mem_addr, bytes_sent}, '0);
    resetn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      bad = bad | (txd !== 1'b1) | (busy !== 1'b0) | (done !== 1'b0) | (mem_if.mem_en !== 1'b0);
    end
    check("idle_quiet", bad, 1'b0);

    // Three-byte dump with latency and back-to-back framing
    d0 = done_cnt;
    kick(18'h00100, 18'd3);
    check("fetch0", {busy, mem_if.mem_en, 14'd0, mem_if.mem_addr}, {1'b1, 1'b1, 14'd0, 18'h00100});
    tick();
    check("latch_txd_hi", {txd, mem_if.mem_en}, 2'b10);
    tick();
    check("start_at_cyc3", txd, 1'b0);
    recv(b, ok, -1);
    check("frm_55", {ok, b}, {1'b1, 8'h55});
    check("cnt_after_1", bytes_sent, 18'd1);
    check("b2b_1", txd, 1'b0);
    recv(b, ok, -1);
    check("frm_a3", {ok, b}, {1'b1, 8'hA3});
    check("b2b_2", txd, 1'b0);
    recv(b, ok, -1);
    check("frm_00", {ok, b}, {1'b1, 8'h00});
`ifdef DSK_TX_CHECKSUM_EN
    check("b2b_ck", txd, 1'b0);
    recv(b, ok, -1);
    check("frm_ck_f8", {ok, b}, {1'b1, 8'hF8});
`endif
    check("done_pulse", {done, busy, txd}, 3'b111);
    tick();
    check("done_end", {done, busy}, 2'b00);
    check("sent_3", bytes_sent, 18'd3);
    check("done_once", done_cnt - d0, 1);

    // Address wrap at the top of the BRAM
    e0 = en_cnt;
    kick(18'h3FFFF, 18'd2);
    check("wrap_addr0", {mem_if.mem_en, 13'd0, mem_if.mem_addr}, {1'b1, 13'd0, 18'h3FFFF});
    tick(); tick();
    recv(b, ok, -1);
    check("frm_12", {ok, b}, {1'b1, 8'h12});
    recv(b, ok, -1);
    check("frm_34", {ok, b}, {1'b1, 8'h34});
`ifdef DSK_TX_CHECKSUM_EN
    recv(b, ok, -1);
    check("frm_ck_46", {ok, b}, {1'b1, 8'h46});
`endif
    check("wrap_reads", en_cnt - e0, 2);
    check("wrap_addr1", last_addr, 18'h00000);
    check("wrap_done", done, 1'b1);
    tick();

    // Abort in the middle of the second byte's data bits
    e0 = en_cnt;
    d0 = done_cnt;
    kick(18'h00200, 18'd5);
    tick(); tick();
    recv(b, ok, -1);
    check("abt_frm_11", {ok, b}, {1'b1, 8'h11});
    recv(b, ok, 70);
    check("abt_frm_22", {ok, b}, {1'b1, 8'h22});
    check("abt_state", {busy, done, txd}, 3'b001);
    check("abt_sent", bytes_sent, 18'd2);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      bad = bad | (txd !== 1'b1) | (busy !== 1'b0) | (done !== 1'b0) | (mem_if.mem_en !== 1'b0);
    end
    check("abt_quiet", bad, 1'b0);
    check("abt_reads", en_cnt - e0, 2);
    check("abt_no_done", done_cnt - d0, 0);

    // Abort while idle has no effect on the next dump
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // Zero-length dump
    d0 = done_cnt;
    kick(18'h00100, 18'd0);
`ifdef DSK_TX_CHECKSUM_EN
    check("len0_start", {txd, busy}, 2'b01);
    recv(b, ok, -1);
    check("len0_frm", {ok, b}, {1'b1, 8'h00});
`endif
    check("len0_done", {done, busy}, 2'b11);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bad = bad | (txd !== 1'b1) | (busy !== 1'b0) | (done !== 1'b0);
    end
    check("len0_quiet", bad, 1'b0);
    check("len0_done_once", done_cnt - d0, 1);
    check("len0_sent", bytes_sent, 18'd0);

    // Asynchronous reset during data bits, then a normal one-byte dump
    kick(18'h00100, 18'd3);
    tick(); tick();
    for (int i = 0; i < 40; i++) tick();
    check("pre_rst_txd", txd, 1'b0);
    resetn = 1'b0;
    #1;
    check("async_rst", {txd, busy, mem_if.mem_en}, 3'b100);
    tick();
    resetn = 1'b1;
    tick();
    d0 = done_cnt;
    kick(18'h00000, 18'd1);
    tick(); tick();
    check("post_rst_start", txd, 1'b0);
    recv(b, ok, -1);
    check("post_rst_frm", {ok, b}, {1'b1, 8'h34});
`ifdef DSK_TX_CHECKSUM_EN
    recv(b, ok, -1);
    check("post_rst_ck", {ok, b}, {1'b1, 8'h34});
`endif
    check("post_rst_done", done, 1'b1);
    tick();
    check("post_rst_idle", {busy, done}, 2'b00);
    check("post_rst_sent", bytes_sent, 18'd1);
    check("post_rst_done_once", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apple2_dsk_uart_tx.md
Name: apple2_dsk_uart_tx

Overview:
UART transmitter that streams a stored disk image back out to the host over serial, from the disk-image BRAM. It is the read-out counterpart of the UART disk loader. On a start pulse it reads `length` bytes sequentially from `base_addr` through the BRAM read port and sends each byte as an 8N1 frame on `txd`. It runs in the `pix_clk_5x` domain next to the receiver and shares the BRAM port arbitration with it.

Parameters:
- CLK_HZ, 125000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- ADDR_W, 18, BRAM byte-address width.
- DIVISOR, CLK_HZ/BAUD (integer division, 1085 at defaults), clock cycles per bit. Derived localparam, not overridable.

Ports:
- clk  in  1  Transmit clock (`pix_clk_5x`).
- resetn  in  1  Asynchronous active-low reset.
- start  in  1  One-cycle request to begin a dump. Sampled only in IDLE.
- abort  in  1  Stop the dump after the current frame completes.
- base_addr  in  ADDR_W  First BRAM address. Latched on start.
- length  in  ADDR_W  Number of image bytes to send. Latched on start.
- mem_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_W  BRAM read address.
- mem_data  in  8  BRAM read data, valid exactly one cycle after mem_en.
- txd  out  1  Serial output. Idles high.
- busy  out  1  High while a dump is in progress.
- done  out  1  One-cycle pulse when a dump completes normally.
- bytes_sent  out  ADDR_W  Count of image bytes fully transmitted in the current or last dump.

Behaviour:
- Reset (async, resetn=0):
  - txd=1; busy=0; done=0; mem_en=0; mem_addr=0; bytes_sent=0; FSM=IDLE.
  - An active frame is cut immediately. Line returns high.
- FSM states: IDLE, FETCH, LATCH, START, DATA, STOP, CKSUM (only with the macro), FINISH.
- IDLE:
  - On start=1, latch base_addr and length, clear bytes_sent and the running sum, set busy=1 next cycle.
  - If length=0, go to FINISH; otherwise go to FETCH.
- FETCH: one cycle with mem_en=1 and mem_addr=base+offset; offset starts at 0.
- LATCH: one cycle; capture mem_data into the shift register.
- Latency: txd falls exactly 3 cycles after the start sample cycle (cycle 0 = start sampled, FETCH at 1, LATCH at 2, start bit at 3).
- Framing:
  - START: txd=0 for DIVISOR cycles.
  - DATA: 8 bits, LSB first, DIVISOR cycles each.
  - STOP: txd=1 for DIVISOR cycles.
- Prefetch: on the first STOP cycle, if more bytes remain and abort has not been seen, issue mem_en for the next address. Capture mem_data on the following cycle. The next START begins immediately after STOP, so frames are back-to-back at exactly 10*DIVISOR cycles per byte with no idle gap.
- bytes_sent increments on the last STOP cycle of each image byte.
- Address arithmetic: base+offset is computed modulo 2^ADDR_W and wraps from max to 0 without error.
- Baud counter counts 0..DIVISOR-1 and restarts at each bit boundary.
- abort:
  - Sticky until FINISH.
  - Suppresses the next prefetch and the checksum.
  - The current frame completes, then the FSM goes to IDLE with done=0.
  - abort in IDLE is ignored.
- FINISH: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- start while busy is ignored. start coincident with the FINISH cycle is ignored.
- mem_addr holds its last value when mem_en=0.

Optional Feature:
- Macro: DSK_TX_CHECKSUM_EN.
- Defined:
  - After the last image byte, one extra 8N1 frame carries the 8-bit modular sum of all sent image bytes (CKSUM state). It follows back-to-back, with no BRAM read.
  - done follows that frame.
  - length=0 sends checksum 0x00.
  - bytes_sent does not count the checksum.
- Undefined: no CKSUM state; done follows the last image byte. length=0 sends nothing.

Test Plan (bench uses CLK_HZ=16, BAUD=1, so DIVISOR=16):
- Reset released, idle 100 cycles -> txd=1, busy=0, done=0, mem_en=0 throughout.
- BRAM[0x100..0x102]={0x55,0xA3,0x00}, start with base=0x100, len=3 -> txd falls at cycle 3. Frames decode as 0x55,0xA3,0x00 back-to-back (480 cycles of frames). bytes_sent=3. done pulses one cycle after the final stop; with the macro, a fourth frame 0xF8 precedes done.
- base=0x3FFFF, len=2, BRAM[0x3FFFF]=0x12, BRAM[0]=0x34 -> mem_addr sequence 0x3FFFF then 0x00000; frames 0x12,0x34.
- len=5, abort asserted mid-DATA of byte 2 -> byte 2 frame completes intact, no further mem_en, busy drops, done stays 0, bytes_sent=2.
- len=0 start -> no frame (macro undefined) or single 0x00 frame (macro defined); done pulses once.
- resetn asserted mid-DATA -> txd=1 asynchronously in the same cycle. A subsequent start with base=0, len=1 transmits normally.
